// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: forwarding-select and load-use stall controller for a 5-stage pipeline.
// Inputs:  clk, rst (sync, active-high), ID-stage operand/dest info (id_*), ex_flush.
// Outputs: stall (comb), ex_bubble/fwd_a/fwd_b (registered, valid in EX),
//          stall_cnt/fwd_cnt (saturating statistics).
module fwd_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              ex_flush,
  output logic              stall,
  output logic              ex_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  fwd_cnt
);
  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              rw;
    logic              mr;
  } stage_t;
  // index 0 = EX, 1 = MEM, 2 = WB shadow
  stage_t stage_q [3];
  stage_t ex_d;
  logic [1:0] fwd_a_d, fwd_b_d, fwd_a_q, fwd_b_q;
  logic ex_bubble_q;
  logic [CNT_W-1:0] stall_cnt_q, fwd_cnt_q;
  function automatic logic writes(input stage_t s, input logic [REG_AW-1:0] r);
    return s.v && s.rw && s.rd == r && r != '0;
  endfunction
  function automatic logic [1:0] sel(input logic use_r, input logic [REG_AW-1:0] r, input stage_t ex,
                                     input stage_t mem, input logic live);
    return (!live || !use_r) ? 2'd0 : writes(ex, r) ? 2'd1 : writes(mem, r) ? 2'd2 : 2'd0;
  endfunction
  always_comb begin
    stall   = id_valid && !ex_flush && stage_q[0].mr &&
              ((id_use_rs && writes(stage_q[0], id_rs)) || (id_use_rt && writes(stage_q[0], id_rt)));
    ex_d    = (stall || ex_flush || !id_valid) ? '0 :
              stage_t'{v: 1'b1, rd: id_rd, rw: id_regwrite, mr: id_memread};
    fwd_a_d = sel(id_use_rs, id_rs, stage_q[0], stage_q[1], ex_d.v);
    fwd_b_d = sel(id_use_rt, id_rt, stage_q[0], stage_q[1], ex_d.v);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q[0]  <= '0;
      stage_q[1]  <= '0;
      stage_q[2]  <= '0;
      fwd_a_q     <= 2'd0;
      fwd_b_q     <= 2'd0;
      ex_bubble_q <= 1'b1;
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stage_q[2]  <= stage_q[1];
      stage_q[1]  <= stage_q[0];
      stage_q[0]  <= ex_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      ex_bubble_q <= !ex_d.v;
      if (stall && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if ((fwd_a_q != 2'd0 || fwd_b_q != 2'd0) && !(&fwd_cnt_q)) fwd_cnt_q <= fwd_cnt_q + CNT_W'(1);
    end
  end
  assign ex_bubble = ex_bubble_q;
  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed checks of forwarding selects, load-use stall, flush and counters.
module tb_fwd_hazard_unit;
  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread, ex_flush;
  logic [4:0] id_rs, id_rt, id_rd;
  logic stall, ex_bubble, s_stall, s_ex_bubble;
  logic [1:0] fwd_a, fwd_b, s_fwd_a, s_fwd_b;
  logic [31:0] stall_cnt, fwd_cnt;
  logic [1:0] s_stall_cnt, s_fwd_cnt;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  fwd_hazard_unit u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .ex_flush(ex_flush), .stall(stall), .ex_bubble(ex_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
  );
  fwd_hazard_unit #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .ex_flush(ex_flush), .stall(s_stall), .ex_bubble(s_ex_bubble),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall_cnt(s_stall_cnt), .fwd_cnt(s_fwd_cnt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic id(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                    input logic urt, input logic [4:0] rd, input logic rw, input logic mr);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_rd = rd; id_regwrite = rw; id_memread = mr;
    #1;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      id(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask
  initial begin
    rst = 1'b1;
    ex_flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      id($urandom_range(0, 1), 5'($urandom), 5'($urandom), $urandom_range(0, 1), $urandom_range(0, 1),
         5'($urandom), $urandom_range(0, 1), $urandom_range(0, 1));
      ex_flush = 1'($urandom_range(0, 1));
      @(posedge clk);
    end
    #1;
    rst = 1'b0;
    ex_flush = 1'b0;
    id(0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_stall", stall, 0);
    check("rst_fwd_a", fwd_a, 0);
    check("rst_fwd_b", fwd_b, 0);
    check("rst_bubble", ex_bubble, 1);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_fwd_cnt", fwd_cnt, 0);
    id(1, 0, 0, 0, 0, 1, 1, 0);
    tick();
    check("first_valid_bubble", ex_bubble, 0);
    nops(3);
    // EX-distance forward on both operands
    id(1, 1, 2, 1, 1, 3, 1, 0);
    tick();
    id(1, 3, 3, 1, 1, 5, 1, 0);
    check("ex_fwd_stall", stall, 0);
    tick();
    check("ex_fwd_a", fwd_a, 1);
    check("ex_fwd_b", fwd_b, 1);
    nops(1);
    check("ex_fwd_cnt", fwd_cnt, 1);
    // MEM-distance forward
    id(1, 0, 0, 0, 0, 3, 1, 0);
    tick();
    nops(1);
    id(1, 3, 0, 1, 0, 7, 1, 0);
    tick();
    check("mem_fwd_a", fwd_a, 2);
    check("mem_fwd_b", fwd_b, 0);
    // nearer stage priority
    id(1, 0, 0, 0, 0, 3, 1, 0);
    tick();
    id(1, 0, 0, 0, 0, 3, 1, 0);
    tick();
    id(1, 3, 0, 1, 0, 7, 1, 0);
    tick();
    check("prio_fwd_a", fwd_a, 1);
    nops(3);
    check("fwd_cnt_3", fwd_cnt, 3);
    // load-use on rt
    id(1, 0, 0, 0, 0, 4, 1, 1);
    tick();
    id(1, 1, 4, 1, 1, 8, 1, 0);
    check("lu_stall", stall, 1);
    tick();
    check("lu_stall_once", stall, 0);
    check("lu_bubble", ex_bubble, 1);
    check("lu_stall_cnt", stall_cnt, 1);
    check("lu_sat_cnt", s_stall_cnt, 1);
    tick();
    check("lu_retry_b", fwd_b, 2);
    check("lu_retry_a", fwd_a, 0);
    check("lu_retry_bubble", ex_bubble, 0);
    nops(3);
    // r0 never forwards
    id(1, 0, 0, 0, 0, 0, 1, 0);
    tick();
    id(1, 0, 0, 1, 1, 9, 1, 0);
    tick();
    check("r0_fwd_a", fwd_a, 0);
    check("r0_fwd_b", fwd_b, 0);
    // unused operand does not stall
    id(1, 0, 0, 0, 0, 6, 1, 1);
    tick();
    id(1, 1, 6, 1, 0, 10, 1, 0);
    check("unused_stall", stall, 0);
    tick();
    check("unused_bubble", ex_bubble, 0);
    check("unused_fwd_b", fwd_b, 0);
    nops(3);
    // flush overrides stall
    id(1, 0, 0, 0, 0, 4, 1, 1);
    tick();
    id(1, 1, 4, 1, 1, 8, 1, 0);
    ex_flush = 1'b1;
    #1;
    check("flush_stall", stall, 0);
    tick();
    ex_flush = 1'b0;
    check("flush_bubble", ex_bubble, 1);
    check("flush_fwd_b", fwd_b, 0);
    check("flush_stall_cnt", stall_cnt, 1);
    nops(3);
    // five more load-use stalls; 2-bit counter saturates
    for (int i = 0; i < 5; i++) begin
      id(1, 0, 0, 0, 0, 4, 1, 1);
      tick();
      id(1, 1, 4, 1, 1, 8, 1, 0);
      tick();
      tick();
    end
    nops(3);
    check("cnt_stall_6", stall_cnt, 6);
    check("sat_stall_cnt", s_stall_cnt, 3);
    check("sat_fwd_cnt", s_fwd_cnt, 3);
    // reset during a stall
    id(1, 0, 0, 0, 0, 4, 1, 1);
    tick();
    id(1, 1, 4, 1, 1, 8, 1, 0);
    check("pre_rst_stall", stall, 1);
    rst = 1'b1;
    tick();
    check("mid_rst_stall", stall, 0);
    check("mid_rst_cnt", stall_cnt, 0);
    check("mid_rst_bubble", ex_bubble, 1);
    rst = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Forwarding and load-use hazard controller for the 5-stage forwarding pipeline.
- Keeps its own shadow copy of destination info for the EX, MEM and WB stages.
- Produces registered 2-bit select codes for the ALU operand 4-input muxes. The codes are valid during the EX cycle of each instruction.
- Drives the stall and bubble signals, and keeps stall and forward statistics counters for the board display.

Parameters:
REG_AW, 5, register-number width
CNT_W, 32, statistics counter width

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
id_valid  input  1  ID holds a real instruction (0 = bubble)
id_rs  input  REG_AW  source register A of the ID instruction
id_rt  input  REG_AW  source register B of the ID instruction
id_use_rs  input  1  ID instruction reads rs
id_use_rt  input  1  ID instruction reads rt
id_rd  input  REG_AW  destination register of the ID instruction
id_regwrite  input  1  ID instruction writes the register file
id_memread  input  1  ID instruction is a load
ex_flush  input  1  branch/jump taken in EX; the ID instruction is wrong-path
stall  output  1  combinational; holds PC and IF/ID
ex_bubble  output  1  registered; the instruction now in EX is a bubble
fwd_a  output  2  registered ALU operand A select: 0 regfile, 1 EX/MEM result, 2 MEM/WB result, 3 never driven
fwd_b  output  2  same encoding, for operand B
stall_cnt  output  CNT_W  number of load-use stall cycles
fwd_cnt  output  CNT_W  number of EX cycles with fwd_a!=0 or fwd_b!=0

Behaviour:
- Shadow stages: EX, MEM and WB. Each holds {valid, rd, regwrite, memread}. They advance every cycle: WB<=MEM, MEM<=EX, EX<=new entry.
- "Writes r" for a stage means: valid && regwrite && rd==r && r!=0.
- stall = id_valid && !ex_flush && EX.memread && EX writes the register of (id_use_rs ? id_rs) or (id_use_rt ? id_rt).
- New EX entry:
  - Bubble (valid=0, regwrite=0, memread=0) if stall, ex_flush or !id_valid.
  - Otherwise the ID fields.
- ex_bubble <= inverse of the new EX entry's valid.
- fwd_a next value (computed in ID, registered into EX):
  - 0 if the new EX entry is a bubble, or !id_use_rs.
  - Else 1 if the current EX shadow writes id_rs; that stage will be in MEM during the next cycle.
  - Else 2 if the current MEM shadow writes id_rs.
  - Else 0.
  - The nearer stage has priority.
- fwd_b: identical rule, using id_rt and id_use_rt.
- A load in the EX shadow never gives code 1, because stall suppresses it. After the one-cycle stall the load sits in MEM, so the retried instruction gets code 2.
- WB-stage match gives code 0. The register file writes in the first half-cycle, so it reads correctly.
- Latency:
  - stall: same cycle as the ID compare.
  - fwd_a, fwd_b, ex_bubble: 1 cycle after ID.
- Stall length: exactly 1 cycle per load-use pair. A second stall cannot follow, because the EX shadow is then a bubble.
- ex_flush:
  - Overrides stall; stall=0 in that cycle.
  - Inserts a bubble into EX.
  - Does not disturb the MEM and WB shadows.
- Counters:
  - stall_cnt increments on each cycle with stall=1.
  - fwd_cnt increments on each cycle in which the registered fwd_a or fwd_b is nonzero.
  - Both saturate at all-ones (no wrap).
- Reset:
  - All shadow valid/regwrite/memread bits 0.
  - fwd_a=fwd_b=0, ex_bubble=1, both counters 0.
  - stall evaluates 0.
- Reset asserted mid-stall takes priority over every update. stall is 0 in the next cycle.

Test Plan:
1. Reset: hold rst for 2 cycles with random ID inputs, then release. Expect stall=0, fwd_a=fwd_b=0, ex_bubble=1 and counters 0 at release; ex_bubble falls one cycle after the first valid ID.
2. EX-distance forward: add r3 in cycle 0, then add r5,r3,r3 in cycle 1. Expect fwd_a=fwd_b=1 in the cycle after the consumer's ID, and fwd_cnt=1.
3. Two-stage distance and priority:
   - add r3, nop, use r3 → fwd_a=2.
   - Two back-to-back writes of r3, then use r3 → fwd_a=1 (nearer stage wins).
4. Load-use: lw r4, then use of r4 in rt.
   - stall=1 for exactly one cycle; ex_bubble=1 the next cycle; stall_cnt=1.
   - On the retry, fwd_b=2 and fwd_a=0.
5. Zero register and unused operands:
   - Writer of r0 followed by a reader of r0 → fwd=0.
   - Load to r6, then an instruction with id_rt=6 but id_use_rt=0 → no stall.
6. Flush and counter saturation:
   - Load-use pair with ex_flush=1 in the consumer's ID cycle → stall=0 and ex_bubble=1 next.
   - With CNT_W=2 and 5 load-use stalls → stall_cnt holds at 3.
